fmap_pad_streamer: RTL and testbench

Producer end of the pixel-vector stream consumed by the 3x3 kernel window generator. Reads an unpadded feature map from on-chip buffer memory and emits it in window order: row-major, 8-channel vector groups innermost. A one-pixel zero border is inserted on all four sides in-stream, so the window consumer sees a (W+2) x (H+2) padded image. Sits between the feature-map BRAM read port and the kernel window `pixel_in`/`data_valid` inputs.

---
 rtl/fmap_stream_pkg.sv | 23 ++
 rtl/stream_skid_fifo.sv | 56 +++++
 rtl/fmap_pad_streamer.sv | 179 +++++++++++++++++
 tb/tb_fmap_pad_streamer.sv | 436 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fmap_stream_pkg.sv
// Shared types and constants for the feature-map pixel-vector stream.
package fmap_stream_pkg;

  localparam int DATA_W     = 64;
  localparam int LANES      = 8;
  localparam int LANE_SHIFT = $clog2(LANES);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RUN,
    ST_DRAIN,
    ST_DONE
  } stream_state_t;

  typedef struct packed {
    logic pad;
  } beat_tag_t;

  function automatic logic [31:0] groups_of(input logic [15:0] channels);
    return 32'(channels >> LANE_SHIFT);
  endfunction

endpackage

// File: rtl/stream_skid_fifo.sv
// Two-entry skid FIFO with head-of-queue output; shared by the feature-map
// producer and the conv output side.
module stream_skid_fifo #(
  parameter int W = 64
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         wr,
  input  logic [W-1:0] wdata,
  input  logic         rd,
  output logic [1:0]   count,
  output logic [W-1:0] head
);

  logic [W-1:0] mem_q [2];
  logic [W-1:0] mem_d [2];
  logic         wptr_q, wptr_d;
  logic         rptr_q, rptr_d;
  logic [1:0]   count_q, count_d;
  logic         do_wr, do_rd;

  always_comb begin
    do_rd   = rd && (count_q != 2'd0);
    // A full FIFO still accepts a write when the head leaves in the same cycle.
    do_wr   = wr && ((count_q != 2'd2) || do_rd);
    mem_d   = mem_q;
    wptr_d  = wptr_q;
    rptr_d  = rptr_q;
    if (do_wr) begin
      mem_d[wptr_q] = wdata;
      wptr_d        = ~wptr_q;
    end
    if (do_rd) begin
      rptr_d = ~rptr_q;
    end
    count_d = count_q + 2'(do_wr) - 2'(do_rd);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_q   <= '{default: '0};
      wptr_q  <= 1'b0;
      rptr_q  <= 1'b0;
      count_q <= '0;
    end else begin
      mem_q   <= mem_d;
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      count_q <= count_d;
    end
  end

  assign count = count_q;
  assign head  = mem_q[rptr_q];

endmodule

// File: rtl/fmap_pad_streamer.sv
// Streams an unpadded feature map from buffer memory in window order
// (row, column, channel group), inserting a one-pixel zero border in-stream.
module fmap_pad_streamer
  import fmap_stream_pkg::*;
#(
  parameter int ADDR_W = 16,
  parameter int DATA_W = fmap_stream_pkg::DATA_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [15:0]       in_channels,
  input  logic [15:0]       img_width,
  input  logic [15:0]       img_height,
  input  logic [ADDR_W-1:0] base_addr,
  output logic              mem_rd_en,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              stall,
  output logic [DATA_W-1:0] pixel_out,
  output logic              data_valid,
  output logic              busy,
  output logic              done
);

  stream_state_t     state_q, state_d;
  logic [31:0]       grps_q, grps_d;
  logic [31:0]       pw_q, pw_d;
  logic [31:0]       ph_q, ph_d;
  logic [31:0]       row_q, row_d;
  logic [31:0]       col_q, col_d;
  logic [31:0]       grp_q, grp_d;
  logic [ADDR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic              stg_vld_q, stg_vld_d;
  beat_tag_t         stg_tag_q, stg_tag_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;

  logic [1:0]        fifo_cnt;
  logic [DATA_W-1:0] fifo_head;
  logic [DATA_W-1:0] fifo_wdata;
  logic              fifo_pop;
  logic [31:0]       occ;
  logic [31:0]       start_grps;
  logic              issue, is_pad, is_last;

  stream_skid_fifo #(
    .W (DATA_W)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .wr    (stg_vld_q),
    .wdata (fifo_wdata),
    .rd    (fifo_pop),
    .count (fifo_cnt),
    .head  (fifo_head)
  );

  always_comb begin
    fifo_pop   = (fifo_cnt != 2'd0) && !stall;
    fifo_wdata = stg_tag_q.pad ? '0 : mem_rdata;
    // Occupancy is counted after this cycle's pop so unstalled flow sustains
    // one beat per cycle while still never overfilling the two entries.
    occ        = 32'(fifo_cnt) + 32'(stg_vld_q) - 32'(fifo_pop);
    issue      = (state_q == ST_RUN) && (occ < 32'd2);
    is_pad     = (row_q == 32'd0) || (row_q == ph_q - 32'd1) ||
                 (col_q == 32'd0) || (col_q == pw_q - 32'd1);
    is_last    = (row_q == ph_q - 32'd1) && (col_q == pw_q - 32'd1) &&
                 (grp_q == grps_q - 32'd1);
    start_grps = groups_of(in_channels);

    state_d       = state_q;
    grps_d        = grps_q;
    pw_d          = pw_q;
    ph_d          = ph_q;
    row_d         = row_q;
    col_d         = col_q;
    grp_d         = grp_q;
    rd_ptr_d      = rd_ptr_q;
    busy_d        = busy_q;
    done_d        = 1'b0;
    stg_vld_d     = issue;
    stg_tag_d     = '0;
    stg_tag_d.pad = is_pad;

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          if ((start_grps == 32'd0) || (img_width == 16'd0) || (img_height == 16'd0)) begin
            state_d = ST_DONE;
            done_d  = 1'b1;
          end else begin
            grps_d   = start_grps;
            pw_d     = 32'(img_width) + 32'd2;
            ph_d     = 32'(img_height) + 32'd2;
            row_d    = '0;
            col_d    = '0;
            grp_d    = '0;
            rd_ptr_d = base_addr;
            busy_d   = 1'b1;
            state_d  = ST_RUN;
          end
        end
      end
      ST_RUN: begin
        if (issue) begin
          if (!is_pad) begin
            rd_ptr_d = rd_ptr_q + ADDR_W'(1);
          end
          if (grp_q == grps_q - 32'd1) begin
            grp_d = '0;
            if (col_q == pw_q - 32'd1) begin
              col_d = '0;
              row_d = row_q + 32'd1;
            end else begin
              col_d = col_q + 32'd1;
            end
          end else begin
            grp_d = grp_q + 32'd1;
          end
          if (is_last) begin
            state_d = ST_DRAIN;
          end
        end
      end
      ST_DRAIN: begin
        if (!stg_vld_q && ((fifo_cnt == 2'd0) || ((fifo_cnt == 2'd1) && fifo_pop))) begin
          state_d = ST_DONE;
          done_d  = 1'b1;
          busy_d  = 1'b0;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      grps_q    <= '0;
      pw_q      <= '0;
      ph_q      <= '0;
      row_q     <= '0;
      col_q     <= '0;
      grp_q     <= '0;
      rd_ptr_q  <= '0;
      stg_vld_q <= 1'b0;
      stg_tag_q <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      grps_q    <= grps_d;
      pw_q      <= pw_d;
      ph_q      <= ph_d;
      row_q     <= row_d;
      col_q     <= col_d;
      grp_q     <= grp_d;
      rd_ptr_q  <= rd_ptr_d;
      stg_vld_q <= stg_vld_d;
      stg_tag_q <= stg_tag_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
    end
  end

  assign mem_rd_en  = issue && !is_pad;
  assign mem_addr   = rd_ptr_q;
  assign data_valid = fifo_pop;
  assign pixel_out  = fifo_head;
  assign busy       = busy_q;
  assign done       = done_q;

endmodule

// File: tb/tb_fmap_pad_streamer.sv
// Self-checking bench for fmap_pad_streamer: padded-frame reference model,
// behavioural memory, random stall, degenerate configs and mid-frame reset.
module tb_fmap_pad_streamer;

  localparam int AW = 16;
  localparam int DW = 64;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0;
  logic          stall = 1'b0;
  logic [15:0]   in_channels = '0;
  logic [15:0]   img_width = '0;
  logic [15:0]   img_height = '0;
  logic [AW-1:0] base_addr = '0;
  logic          mem_rd_en;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_rdata = '0;
  logic [DW-1:0] pixel_out;
  logic          data_valid, busy, done;

  always #5 clk = ~clk;

  fmap_pad_streamer #(
    .ADDR_W (AW),
    .DATA_W (DW)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (start),
    .in_channels (in_channels),
    .img_width   (img_width),
    .img_height  (img_height),
    .base_addr   (base_addr),
    .mem_rd_en   (mem_rd_en),
    .mem_addr    (mem_addr),
    .mem_rdata   (mem_rdata),
    .stall       (stall),
    .pixel_out   (pixel_out),
    .data_valid  (data_valid),
    .busy        (busy),
    .done        (done)
  );

  int            errors = 0;
  int            checks = 0;
  int            cyc = 0;
  int            stall_pct = 0;
  logic [31:0]   mem_seed = 32'h1234_5678;
  logic [DW-1:0] got_beats[$];
  logic [DW-1:0] exp_beats[$];
  logic [AW-1:0] got_addrs[$];
  logic [AW-1:0] exp_addrs[$];
  int            first_cyc, last_cyc, done_cnt, done_cyc, stall_viol, busy_cnt;
  int            start_edge;

  // Memory contents are a hash of the address so every word is distinct and nonzero.
  function automatic logic [DW-1:0] memf(input logic [AW-1:0] a);
    logic [31:0] x;
    x = ({16'h0, a} * 32'h9E37_79B1) ^ mem_seed;
    return {x ^ 32'h5A5A_0001, 16'hBEEF, a};
  endfunction

  // Read data returns one cycle after the strobe; garbage otherwise.
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (mem_rd_en) mem_rdata <= memf(mem_addr);
    else           mem_rdata <= {$urandom, $urandom};
  end

  always @(negedge clk) begin
    if (rst_n) begin
      if (data_valid) begin
        got_beats.push_back(pixel_out);
        if (first_cyc < 0) first_cyc = cyc;
        last_cyc = cyc;
        if (stall) stall_viol++;
      end
      if (mem_rd_en) got_addrs.push_back(mem_addr);
      if (done) begin
        done_cnt++;
        done_cyc = cyc;
      end
      if (busy) busy_cnt++;
    end
  end

  initial begin
    forever begin
      @(posedge clk);
      #1;
      stall = (stall_pct > 0) && (int'($urandom_range(99)) < stall_pct);
    end
  end

  // Expected stream built straight from the padding rules.
  task automatic build_model(input logic [15:0] cin, input logic [15:0] w,
                             input logic [15:0] h, input logic [AW-1:0] base);
    int d, pw, ph;
    logic [AW-1:0] p;
    d  = int'(cin) / 8;
    pw = int'(w) + 2;
    ph = int'(h) + 2;
    p  = base;
    exp_beats.delete();
    exp_addrs.delete();
    if (d == 0 || w == 0 || h == 0) return;
    for (int r = 0; r < ph; r++)
      for (int c = 0; c < pw; c++)
        for (int g = 0; g < d; g++) begin
          if (r == 0 || r == ph - 1 || c == 0 || c == pw - 1) begin
            exp_beats.push_back('0);
          end else begin
            exp_beats.push_back(memf(p));
            exp_addrs.push_back(p);
            p = p + 1'b1;
          end
        end
  endtask

  task automatic clear_mon();
    got_beats.delete();
    got_addrs.delete();
    first_cyc  = -1;
    last_cyc   = -1;
    done_cnt   = 0;
    done_cyc   = -1;
    stall_viol = 0;
    busy_cnt   = 0;
  endtask

  task automatic launch(input logic [15:0] cin, input logic [15:0] w,
                        input logic [15:0] h, input logic [AW-1:0] base);
    @(posedge clk);
    #1;
    in_channels = cin;
    img_width   = w;
    img_height  = h;
    base_addr   = base;
    start       = 1'b1;
    @(posedge clk);
    #1;
    start_edge  = cyc;
    start       = 1'b0;
    in_channels = 16'($urandom);
    img_width   = 16'($urandom);
    img_height  = 16'($urandom);
    base_addr   = 16'($urandom);
  endtask

  task automatic wait_done(input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (done_cnt > 0) begin
        ok = 1'b1;
        break;
      end
    end
    repeat (3) @(negedge clk);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    #12;
    checks += 5;
    if (data_valid !== 1'b0) begin errors++; $display("FAIL reset_data_valid got=%b exp=0", data_valid); end
    if (mem_rd_en !== 1'b0)  begin errors++; $display("FAIL reset_mem_rd_en got=%b exp=0", mem_rd_en); end
    if (busy !== 1'b0)       begin errors++; $display("FAIL reset_busy got=%b exp=0", busy); end
    if (done !== 1'b0)       begin errors++; $display("FAIL reset_done got=%b exp=0", done); end
    if (pixel_out !== '0)    begin errors++; $display("FAIL reset_pixel_out got=%h exp=0", pixel_out); end
    @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  task automatic test_basic();
    bit ok;
    stall_pct = 0;
    build_model(16'd8, 16'd2, 16'd2, 16'h0100);
    clear_mon();
    launch(16'd8, 16'd2, 16'd2, 16'h0100);
    checks++;
    if (busy !== 1'b1) begin errors++; $display("FAIL basic_busy got=%b exp=1", busy); end
    wait_done(200, ok);
    checks++;
    if (!ok) begin errors++; $display("FAIL basic_timeout got=no_done exp=done"); end
    checks++;
    if (got_beats.size() != 16) begin errors++; $display("FAIL basic_beat_count got=%0d exp=16", got_beats.size()); end
    for (int i = 0; i < exp_beats.size() && i < got_beats.size(); i++) begin
      checks++;
      if (got_beats[i] !== exp_beats[i]) begin
        errors++; $display("FAIL basic_beat[%0d] got=%h exp=%h", i, got_beats[i], exp_beats[i]);
      end
    end
    checks++;
    if (got_addrs.size() != 4) begin errors++; $display("FAIL basic_read_count got=%0d exp=4", got_addrs.size()); end
    for (int i = 0; i < got_addrs.size() && i < 4; i++) begin
      checks++;
      if (got_addrs[i] !== 16'(16'h0100 + i)) begin
        errors++; $display("FAIL basic_addr[%0d] got=%h exp=%h", i, got_addrs[i], 16'(16'h0100 + i));
      end
    end
    checks += 5;
    if (first_cyc != start_edge + 2) begin errors++; $display("FAIL basic_latency got=%0d exp=%0d", first_cyc - start_edge, 2); end
    if (last_cyc - first_cyc != 15) begin errors++; $display("FAIL basic_back_to_back got_span=%0d exp=15", last_cyc - first_cyc); end
    if (done_cnt != 1) begin errors++; $display("FAIL basic_done_count got=%0d exp=1", done_cnt); end
    if (done_cyc != last_cyc + 1) begin errors++; $display("FAIL basic_done_timing got=%0d exp=%0d", done_cyc, last_cyc + 1); end
    if (busy !== 1'b0) begin errors++; $display("FAIL basic_busy_end got=%b exp=0", busy); end
  endtask

  task automatic test_wide();
    bit ok;
    logic [AW-1:0] b;
    b = 16'($urandom);
    stall_pct = 0;
    build_model(16'd16, 16'd1, 16'd1, b);
    clear_mon();
    launch(16'd16, 16'd1, 16'd1, b);
    wait_done(200, ok);
    checks += 4;
    if (!ok) begin errors++; $display("FAIL wide_timeout got=no_done exp=done"); end
    if (got_beats.size() != 18) begin errors++; $display("FAIL wide_beat_count got=%0d exp=18", got_beats.size()); end
    if (got_beats.size() > 9 && got_beats[8] !== memf(b)) begin
      errors++; $display("FAIL wide_beat8 got=%h exp=%h", got_beats[8], memf(b));
    end
    if (got_beats.size() > 9 && got_beats[9] !== memf(b + 1'b1)) begin
      errors++; $display("FAIL wide_beat9 got=%h exp=%h", got_beats[9], memf(b + 1'b1));
    end
    for (int i = 0; i < exp_beats.size() && i < got_beats.size(); i++) begin
      checks++;
      if (got_beats[i] !== exp_beats[i]) begin
        errors++; $display("FAIL wide_beat[%0d] got=%h exp=%h", i, got_beats[i], exp_beats[i]);
      end
    end
  endtask

  task automatic test_stall();
    bit ok;
    stall_pct = 50;
    build_model(16'd8, 16'd2, 16'd2, 16'h0100);
    clear_mon();
    launch(16'd8, 16'd2, 16'd2, 16'h0100);
    wait_done(400, ok);
    stall_pct = 0;
    checks += 4;
    if (!ok) begin errors++; $display("FAIL stall_timeout got=no_done exp=done"); end
    if (got_beats.size() != exp_beats.size()) begin
      errors++; $display("FAIL stall_beat_count got=%0d exp=%0d", got_beats.size(), exp_beats.size());
    end
    if (stall_viol != 0) begin errors++; $display("FAIL stall_valid_while_stalled got=%0d exp=0", stall_viol); end
    if (done_cnt != 1) begin errors++; $display("FAIL stall_done_count got=%0d exp=1", done_cnt); end
    for (int i = 0; i < exp_beats.size() && i < got_beats.size(); i++) begin
      checks++;
      if (got_beats[i] !== exp_beats[i]) begin
        errors++; $display("FAIL stall_beat[%0d] got=%h exp=%h", i, got_beats[i], exp_beats[i]);
      end
    end
  endtask

  task automatic test_wrap();
    bit ok;
    logic [AW-1:0] want[3];
    want[0] = 16'hFFFE;
    want[1] = 16'hFFFF;
    want[2] = 16'h0000;
    stall_pct = 0;
    clear_mon();
    launch(16'd8, 16'd3, 16'd1, 16'hFFFE);
    wait_done(200, ok);
    checks += 2;
    if (!ok) begin errors++; $display("FAIL wrap_timeout got=no_done exp=done"); end
    if (got_addrs.size() != 3) begin errors++; $display("FAIL wrap_read_count got=%0d exp=3", got_addrs.size()); end
    for (int i = 0; i < 3 && i < got_addrs.size(); i++) begin
      checks++;
      if (got_addrs[i] !== want[i]) begin
        errors++; $display("FAIL wrap_addr[%0d] got=%h exp=%h", i, got_addrs[i], want[i]);
      end
    end
  endtask

  task automatic test_degenerate();
    bit ok;
    logic [15:0] cfg[3][3];
    cfg[0] = '{16'd4, 16'd2, 16'd2};
    cfg[1] = '{16'd8, 16'd0, 16'd2};
    cfg[2] = '{16'd8, 16'd2, 16'd0};
    stall_pct = 0;
    for (int k = 0; k < 3; k++) begin
      clear_mon();
      launch(cfg[k][0], cfg[k][1], cfg[k][2], 16'h0040);
      wait_done(10, ok);
      checks += 6;
      if (!ok) begin errors++; $display("FAIL degen%0d_timeout got=no_done exp=done", k); end
      if (got_beats.size() != 0) begin errors++; $display("FAIL degen%0d_beats got=%0d exp=0", k, got_beats.size()); end
      if (got_addrs.size() != 0) begin errors++; $display("FAIL degen%0d_reads got=%0d exp=0", k, got_addrs.size()); end
      if (done_cnt != 1) begin errors++; $display("FAIL degen%0d_done_count got=%0d exp=1", k, done_cnt); end
      if (done_cyc - start_edge > 2) begin errors++; $display("FAIL degen%0d_done_delay got=%0d exp<=2", k, done_cyc - start_edge); end
      if (busy_cnt != 0) begin errors++; $display("FAIL degen%0d_busy got=%0d exp=0", k, busy_cnt); end
    end
  endtask

  task automatic test_start_ignored();
    bit ok;
    stall_pct = 0;
    build_model(16'd8, 16'd2, 16'd2, 16'h0200);
    clear_mon();
    launch(16'd8, 16'd2, 16'd2, 16'h0200);
    repeat (5) @(posedge clk);
    #1;
    in_channels = 16'd16;
    img_width   = 16'd5;
    img_height  = 16'd4;
    base_addr   = 16'h0300;
    start       = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    wait_done(200, ok);
    repeat (6) @(negedge clk);
    checks += 4;
    if (!ok) begin errors++; $display("FAIL ignore_timeout got=no_done exp=done"); end
    if (got_beats.size() != exp_beats.size()) begin
      errors++; $display("FAIL ignore_beat_count got=%0d exp=%0d", got_beats.size(), exp_beats.size());
    end
    if (got_addrs.size() != exp_addrs.size()) begin
      errors++; $display("FAIL ignore_read_count got=%0d exp=%0d", got_addrs.size(), exp_addrs.size());
    end
    if (done_cnt != 1) begin errors++; $display("FAIL ignore_done_count got=%0d exp=1", done_cnt); end
    for (int i = 0; i < exp_beats.size() && i < got_beats.size(); i++) begin
      checks++;
      if (got_beats[i] !== exp_beats[i]) begin
        errors++; $display("FAIL ignore_beat[%0d] got=%h exp=%h", i, got_beats[i], exp_beats[i]);
      end
    end
  endtask

  task automatic test_reset_mid_frame();
    bit ok;
    logic [AW-1:0] b;
    stall_pct = 0;
    clear_mon();
    launch(16'd16, 16'd3, 16'd3, 16'h0500);
    repeat (6) @(posedge clk);
    #1 rst_n = 1'b0;
    #1;
    checks += 5;
    if (data_valid !== 1'b0) begin errors++; $display("FAIL midrst_data_valid got=%b exp=0", data_valid); end
    if (mem_rd_en !== 1'b0)  begin errors++; $display("FAIL midrst_mem_rd_en got=%b exp=0", mem_rd_en); end
    if (busy !== 1'b0)       begin errors++; $display("FAIL midrst_busy got=%b exp=0", busy); end
    if (done !== 1'b0)       begin errors++; $display("FAIL midrst_done got=%b exp=0", done); end
    if (pixel_out !== '0)    begin errors++; $display("FAIL midrst_pixel_out got=%h exp=0", pixel_out); end
    @(posedge clk);
    #1 rst_n = 1'b1;
    clear_mon();
    repeat (10) @(negedge clk);
    checks += 2;
    if (done_cnt != 0) begin errors++; $display("FAIL midrst_abandon_done got=%0d exp=0", done_cnt); end
    if (got_beats.size() + got_addrs.size() != 0) begin
      errors++; $display("FAIL midrst_abandon_activity got=%0d exp=0", got_beats.size() + got_addrs.size());
    end
    b = 16'($urandom);
    build_model(16'd8, 16'd3, 16'd2, b);
    clear_mon();
    launch(16'd8, 16'd3, 16'd2, b);
    wait_done(300, ok);
    checks += 3;
    if (!ok) begin errors++; $display("FAIL midrst_timeout got=no_done exp=done"); end
    if (got_beats.size() != exp_beats.size()) begin
      errors++; $display("FAIL midrst_beat_count got=%0d exp=%0d", got_beats.size(), exp_beats.size());
    end
    if (got_addrs != exp_addrs) begin errors++; $display("FAIL midrst_reads got_n=%0d exp_n=%0d", got_addrs.size(), exp_addrs.size()); end
    for (int i = 0; i < exp_beats.size() && i < got_beats.size(); i++) begin
      checks++;
      if (got_beats[i] !== exp_beats[i]) begin
        errors++; $display("FAIL midrst_beat[%0d] got=%h exp=%h", i, got_beats[i], exp_beats[i]);
      end
    end
  endtask

  task automatic test_random();
    bit ok;
    logic [15:0] cin, w, h;
    logic [AW-1:0] b;
    for (int k = 0; k < 6; k++) begin
      mem_seed  = $urandom;
      cin       = 16'(8 * $urandom_range(1, 3));
      w         = 16'($urandom_range(1, 5));
      h         = 16'($urandom_range(1, 4));
      b         = 16'($urandom);
      stall_pct = int'($urandom_range(0, 70));
      build_model(cin, w, h, b);
      clear_mon();
      launch(cin, w, h, b);
      wait_done(2000, ok);
      stall_pct = 0;
      checks += 5;
      if (!ok) begin errors++; $display("FAIL rand%0d_timeout got=no_done exp=done", k); end
      if (got_beats.size() != exp_beats.size()) begin
        errors++; $display("FAIL rand%0d_beat_count got=%0d exp=%0d", k, got_beats.size(), exp_beats.size());
      end
      if (got_addrs != exp_addrs) begin
        errors++; $display("FAIL rand%0d_reads got_n=%0d exp_n=%0d", k, got_addrs.size(), exp_addrs.size());
      end
      if (stall_viol != 0) begin errors++; $display("FAIL rand%0d_valid_while_stalled got=%0d exp=0", k, stall_viol); end
      if (done_cyc != last_cyc + 1) begin errors++; $display("FAIL rand%0d_done_timing got=%0d exp=%0d", k, done_cyc, last_cyc + 1); end
      for (int i = 0; i < exp_beats.size() && i < got_beats.size(); i++) begin
        checks++;
        if (got_beats[i] !== exp_beats[i]) begin
          errors++; $display("FAIL rand%0d_beat[%0d] got=%h exp=%h", k, i, got_beats[i], exp_beats[i]);
        end
      end
    end
  endtask

  initial begin
    #500000;
    errors++;
    $display("FAIL watchdog got=running exp=finished");
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $fatal(1, "watchdog expired");
  end

  initial begin
    test_reset();
    test_basic();
    test_wide();
    test_stall();
    test_wrap();
    test_degenerate();
    test_start_ignored();
    test_reset_mid_frame();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
